coeff_loader: RTL and testbench

Write-side companion of the filter coefficient bank. Accepts a stream of 32-bit coefficient words over a valid/ready handshake, writes them in order into a 10-entry internal register bank, and exposes the whole bank (flattened) plus a `coeff_valid` flag to the coefficient-select mux and the filter datapath. A load is framed by `load_start`. It ends with a one-cycle `load_done` pulse or, on `load_abort`, with a one-cycle `load_err` pulse.

---
 rtl/coeff_loader.sv | 123 ++++++++++++
 tb/tb_coeff_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// Coefficient bank write-side loader: accepts NUM_COEFF words over valid/ready,
// stores them in order and publishes the flattened bank with a completeness flag.
module coeff_loader #(
  parameter int NUM_COEFF = 10,
  parameter int WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_abort,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [NUM_COEFF*WIDTH-1:0] coeff_bank,
  output logic                       coeff_valid,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_COEFF - 1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] bank_q [NUM_COEFF];
  logic [WIDTH-1:0] bank_d [NUM_COEFF];
  logic             coeff_valid_q, coeff_valid_d;
  logic             err_q, err_d;
  logic             accept;

  // Abort wins over a same-cycle word, so that word is never written.
  assign accept = (state_q == S_LOAD) && din_valid && !load_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load_start) state_d = S_LOAD;
      S_LOAD: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (accept && (idx_q == LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state_q == S_LOAD);
    load_busy = (state_q != S_IDLE);
    load_done = (state_q == S_DONE);
  end

  always_comb begin
    idx_d         = idx_q;
    bank_d        = bank_q;
    coeff_valid_d = coeff_valid_q;
    err_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          idx_d         = 4'd0;
          coeff_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_abort) begin
          err_d = 1'b1;
        end else if (accept) begin
          for (int k = 0; k < NUM_COEFF; k++) begin
            if (idx_q == 4'(k)) bank_d[k] = din;
          end
          // Valid is raised on the final accept so it is already high in DONE.
          if (idx_q == LAST_IDX) begin
            coeff_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DONE:  coeff_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= 4'd0;
      coeff_valid_q <= 1'b0;
      err_q         <= 1'b0;
      for (int k = 0; k < NUM_COEFF; k++) bank_q[k] <= '0;
    end else begin
      idx_q         <= idx_d;
      coeff_valid_q <= coeff_valid_d;
      err_q         <= err_d;
      for (int k = 0; k < NUM_COEFF; k++) bank_q[k] <= bank_d[k];
    end
  end

  assign coeff_valid = coeff_valid_q;
  assign load_err    = err_q;

  for (genvar g = 0; g < NUM_COEFF; g++) begin : g_flat
    assign coeff_bank[g*WIDTH +: WIDTH] = bank_q[g];
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Bench for coeff_loader: transaction-level bank model, per-cycle compare,
// directed scenarios with literal expectations and randomized load episodes.
module tb_coeff_loader;

  localparam int N = 10;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           load_start;
  logic           load_abort;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           din_ready;
  logic [N*W-1:0] coeff_bank;
  logic           coeff_valid;
  logic           load_busy;
  logic           load_done;
  logic           load_err;

  coeff_loader #(.NUM_COEFF(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_abort (load_abort),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .coeff_bank (coeff_bank),
    .coeff_valid(coeff_valid),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = waiting, 1 = collecting words, 2 = completion cycle.
  int          m_phase;
  int          m_cnt;
  logic [W-1:0] m_bank [N];
  bit          m_valid;
  bit          m_err;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] entry(input int k);
    return coeff_bank[k*W +: W];
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int k = 0; k < N; k++) m_bank[k] = '0;
  endtask

  task automatic model_edge(input logic s, input logic a, input logic v, input logic [W-1:0] d);
    m_err = 1'b0;
    if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_cnt   = 0;
        m_valid = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (a) begin
        m_phase = 0;
        m_err   = 1'b1;
      end else if (v) begin
        m_bank[m_cnt] = d;
        m_cnt++;
        if (m_cnt == N) begin
          m_phase = 2;
          m_valid = 1'b1;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic step(input logic s, input logic a, input logic v, input logic [W-1:0] d);
    load_start = s;
    load_abort = a;
    din_valid  = v;
    din        = d;
    @(posedge clk);
    model_edge(s, a, v, d);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("din_ready",   W'(din_ready),   W'(m_phase == 1));
      chk("load_busy",   W'(load_busy),   W'(m_phase != 0));
      chk("load_done",   W'(load_done),   W'(m_phase == 2));
      chk("load_err",    W'(load_err),    W'(m_err));
      chk("coeff_valid", W'(coeff_valid), W'(m_valid));
      for (int k = 0; k < N; k++) chk($sformatf("bank[%0d]", k), entry(k), m_bank[k]);
    end
  end

  task automatic full_load(input logic [W-1:0] base, input logic [W-1:0] inc);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < N; k++) step(1'b0, 1'b0, 1'b1, base + inc * W'(k));
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    din_valid  = 1'b0;
    din        = '0;
    model_reset();
    chk_en = 1'b1;
    #3;
    chk("rst din_ready", W'(din_ready), 0);
    chk("rst load_busy", W'(load_busy), 0);
    chk("rst coeff_valid", W'(coeff_valid), 0);
    chk("rst bank[9]", entry(9), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Full back-to-back load: start at cycle 0, DONE at cycle 11.
    step(1'b1, 1'b0, 1'b0, '0);
    chk("c1 din_ready", W'(din_ready), 1);
    chk("c1 coeff_valid", W'(coeff_valid), 0);
    for (int k = 0; k < N; k++) step(1'b0, 1'b0, 1'b1, W'(k + 1));
    chk("c11 load_done", W'(load_done), 1);
    chk("c11 coeff_valid", W'(coeff_valid), 1);
    chk("c11 din_ready", W'(din_ready), 0);
    chk("c11 load_busy", W'(load_busy), 1);
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] want;
      want = W'(k + 1);
      chk($sformatf("lit bank[%0d]", k), entry(k), want);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    chk("c12 load_done", W'(load_done), 0);
    chk("c12 load_busy", W'(load_busy), 0);

    // Stalled load with a stray load_start mid-way.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < N; k++) begin
      step((k == 4) ? 1'b1 : 1'b0, 1'b0, 1'b0, 32'hFFFF0000);
      step(1'b0, 1'b0, 1'b1, W'(k + 1));
    end
    chk("stall load_done", W'(load_done), 1);
    chk("stall bank[4]", entry(4), 32'h5);
    chk("stall bank[9]", entry(9), 32'hA);
    step(1'b0, 1'b0, 1'b0, '0);

    // Ignored inputs in IDLE.
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    chk("idle bank[0]", entry(0), 32'h1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("idle abort no err", W'(load_err), 0);

    // Abort together with the 4th word.
    full_load(32'hAAAAAAAA, 0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 32'h11111111);
    step(1'b0, 1'b0, 1'b1, 32'h22222222);
    step(1'b0, 1'b0, 1'b1, 32'h33333333);
    step(1'b0, 1'b1, 1'b1, 32'h44444444);
    chk("abort load_err", W'(load_err), 1);
    chk("abort coeff_valid", W'(coeff_valid), 0);
    chk("abort load_busy", W'(load_busy), 0);
    chk("abort bank[2]", entry(2), 32'h33333333);
    chk("abort bank[3]", entry(3), 32'hAAAAAAAA);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("abort err once", W'(load_err), 0);

    // Asynchronous reset after 5 accepts.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 32'h5000 + W'(k));
    load_start = 1'b0;
    din_valid  = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst din_ready", W'(din_ready), 0);
    chk("arst load_busy", W'(load_busy), 0);
    chk("arst bank[0]", entry(0), 0);
    chk("arst bank[5]", entry(5), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    full_load(32'h100, 32'h10);
    chk("post-rst bank[7]", entry(7), 32'h170);
    chk("post-rst coeff_valid", W'(coeff_valid), 1);

    // Randomized episodes.
    for (int e = 0; e < 40; e++) begin
      int idle_n;
      idle_n = $urandom_range(0, 3);
      repeat (idle_n) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      for (int c = 0; c < 60; c++) begin
        if (m_phase == 0) break;
        step(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 3) != 0, $urandom);
      end
    end
    step(1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
